// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_pkg
// Description : Shared fixed-point helpers: extreme codes for a given width
//               and the overflow-select encoding used by the abs, add,
//               saturate and sign-apply blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fixed_point_pkg;

  // Which rail a result would saturate to when it is not representable.
  typedef enum logic [1:0] {
    OVF_NONE = 2'd0,
    OVF_POS  = 2'd1,
    OVF_NEG  = 2'd2
  } ovf_sel_e;

  function automatic logic [63:0] max_pos_code(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] max_neg_code(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_point_negate_stage.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_negate_stage
// Description : One registered sign-apply / two's-complement negation stage
//               with valid/ready. Macro FIXED_POINT_SIGN_APPLY_SAT_EN selects
//               saturating instead of wrapping results on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_negate_stage
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_mag,
  input  logic [WIDTH-1:0] i_mag_inv,
  input  logic             i_sign,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_value,
  output logic             o_ovf
);

`ifdef FIXED_POINT_SIGN_APPLY_SAT_EN
  localparam logic [63:0]      C_MAX_POS_64 = max_pos_code(WIDTH);
  localparam logic [63:0]      C_MAX_NEG_64 = max_neg_code(WIDTH);
  localparam logic [WIDTH-1:0] C_MAX_POS    = C_MAX_POS_64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_MAX_NEG    = C_MAX_NEG_64[WIDTH-1:0];
`endif

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             ovf_q,   ovf_d;
  logic             advance;
  logic [WIDTH-1:0] wrapped;
  ovf_sel_e         ovf_sel;

  always_comb begin
    advance = !valid_q || i_ready;
    wrapped = i_sign ? (i_mag_inv + {{(WIDTH-1){1'b0}}, 1'b1}) : i_mag;

    // Positive range tops out at M-1; negative range reaches exactly -M.
    ovf_sel = OVF_NONE;
    if (!i_sign && i_mag[WIDTH-1]) begin
      ovf_sel = OVF_POS;
    end else if (i_sign && i_mag[WIDTH-1] && (|i_mag[WIDTH-2:0])) begin
      ovf_sel = OVF_NEG;
    end

    valid_d = valid_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    if (advance) begin
      valid_d = i_valid;
      if (i_valid) begin
        ovf_d = (ovf_sel != OVF_NONE);
`ifdef FIXED_POINT_SIGN_APPLY_SAT_EN
        case (ovf_sel)
          OVF_POS: value_d = C_MAX_POS;
          OVF_NEG: value_d = C_MAX_NEG;
          default: value_d = wrapped;
        endcase
`else
        value_d = wrapped;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ready = advance;
  assign o_valid = valid_q;
  assign o_value = value_q;
  assign o_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/fixed_point_sign_apply.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_sign_apply
// Description : Magnitude + sign to signed two's-complement, 2-stage pipeline
//               with valid/ready, per-sample and sticky overflow.
//               Macro FIXED_POINT_SIGN_APPLY_SAT_EN enables saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_sign_apply
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] MAG_IN,
  input  logic             SIGN_IN,
  input  logic             VALID_IN,
  output logic             READY_OUT,
  output logic [WIDTH-1:0] VALUE_OUT,
  output logic             VALID_OUT,
  input  logic             READY_IN,
  output logic             OVERFLOW,
  output logic             OVERFLOW_STICKY,
  input  logic             CLEAR
);

  // The binary point only labels the data; it must still sit inside the word.
  if (FRAC_BITS < 0 || FRAC_BITS > WIDTH) begin : g_frac_range_check
    $error("fixed_point_sign_apply: FRAC_BITS outside 0..WIDTH");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_mag_q,   s1_mag_d;
  logic [WIDTH-1:0] s1_inv_q,   s1_inv_d;
  logic             s1_sign_q,  s1_sign_d;
  logic             sticky_q,   sticky_d;
  logic             s1_advance;
  logic             s2_advance;
  logic             s2_valid;
  logic             s2_ovf;
  logic [WIDTH-1:0] s2_value;

  always_comb begin
    s1_advance = !s1_valid_q || s2_advance;
    s1_valid_d = s1_valid_q;
    s1_mag_d   = s1_mag_q;
    s1_inv_d   = s1_inv_q;
    s1_sign_d  = s1_sign_q;
    if (s1_advance) begin
      s1_valid_d = VALID_IN;
      if (VALID_IN) begin
        s1_mag_d  = MAG_IN;
        s1_inv_d  = ~MAG_IN;
        s1_sign_d = SIGN_IN;
      end
    end

    // CLEAR beats a simultaneous overflowing output transfer.
    sticky_d = sticky_q || (s2_valid && READY_IN && s2_ovf);
    if (CLEAR) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_inv_q   <= '0;
      s1_sign_q  <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mag_q   <= s1_mag_d;
      s1_inv_q   <= s1_inv_d;
      s1_sign_q  <= s1_sign_d;
      sticky_q   <= sticky_d;
    end
  end

  fixed_point_negate_stage #(
    .WIDTH (WIDTH)
  ) u_stage2 (
    .clk       (CLK),
    .rst       (RST),
    .i_valid   (s1_valid_q),
    .o_ready   (s2_advance),
    .i_mag     (s1_mag_q),
    .i_mag_inv (s1_inv_q),
    .i_sign    (s1_sign_q),
    .o_valid   (s2_valid),
    .i_ready   (READY_IN),
    .o_value   (s2_value),
    .o_ovf     (s2_ovf)
  );

  assign READY_OUT       = s1_advance;
  assign VALID_OUT       = s2_valid;
  assign VALUE_OUT       = s2_value;
  assign OVERFLOW        = s2_ovf;
  assign OVERFLOW_STICKY = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_sign_apply.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_point_sign_apply
// Description : Directed and random checks of fixed_point_sign_apply against
//               an arithmetic reference model and a transfer scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_point_sign_apply;

  localparam int W = 8;
  localparam int M = 1 << (W - 1);

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] MAG_IN = '0;
  logic         SIGN_IN = 1'b0;
  logic         VALID_IN = 1'b0;
  logic         READY_OUT;
  logic [W-1:0] VALUE_OUT;
  logic         VALID_OUT;
  logic         READY_IN = 1'b1;
  logic         OVERFLOW;
  logic         OVERFLOW_STICKY;
  logic         CLEAR = 1'b0;

  fixed_point_sign_apply #(.WIDTH(W), .FRAC_BITS(3)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .MAG_IN          (MAG_IN),
    .SIGN_IN         (SIGN_IN),
    .VALID_IN        (VALID_IN),
    .READY_OUT       (READY_OUT),
    .VALUE_OUT       (VALUE_OUT),
    .VALID_OUT       (VALID_OUT),
    .READY_IN        (READY_IN),
    .OVERFLOW        (OVERFLOW),
    .OVERFLOW_STICKY (OVERFLOW_STICKY),
    .CLEAR           (CLEAR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] v;
    bit           ovf;
  } exp_t;

  exp_t q[$];
  bit   sticky_m = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  function automatic exp_t model(input int mag, input bit sign);
    exp_t r;
    int   val;
    val   = sign ? -mag : mag;
    r.ovf = (val > M - 1) || (val < -M);
`ifdef FIXED_POINT_SIGN_APPLY_SAT_EN
    if (r.ovf) val = sign ? -M : M - 1;
`endif
    r.v = W'(val & ((1 << W) - 1));
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate handshakes against the model, then advance to the next negedge.
  task automatic step(output bit acc);
    exp_t         e;
    bit           stall = 1'b0;
    bit           sset  = 1'b0;
    logic [W-1:0] held_v = '0;
    bit           held_o = 1'b0;
    #1;
    acc = 1'b0;
    if (RST) begin
      q.delete();
      sticky_m = 1'b0;
    end else begin
      check("ready_out", 32'(READY_OUT), 32'((q.size() < 2) || READY_IN));
      if (q.size() == 0) check("spurious_valid", 32'(VALID_OUT), 32'd0);
      if (VALID_OUT && READY_IN && q.size() > 0) begin
        e = q.pop_front();
        check("out_value", 32'(VALUE_OUT), 32'(e.v));
        check("out_ovf", 32'(OVERFLOW), 32'(e.ovf));
        sset = e.ovf;
      end
      if (VALID_OUT && !READY_IN) begin
        stall  = 1'b1;
        held_v = VALUE_OUT;
        held_o = OVERFLOW;
      end
      if (VALID_IN && READY_OUT) begin
        q.push_back(model(int'(MAG_IN), SIGN_IN));
        acc = 1'b1;
      end
      sticky_m = CLEAR ? 1'b0 : (sticky_m | sset);
    end
    @(posedge CLK);
    @(negedge CLK);
    check("sticky", 32'(OVERFLOW_STICKY), 32'(sticky_m));
    if (stall && !RST) begin
      check("stall_valid", 32'(VALID_OUT), 32'd1);
      check("stall_value", 32'(VALUE_OUT), 32'(held_v));
      check("stall_ovf", 32'(OVERFLOW), 32'(held_o));
    end
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] mag, input bit sign,
                          input logic [W-1:0] expv, input bit expo, input bit clr);
    bit acc;
    READY_IN = 1'b1; CLEAR = 1'b0;
    VALID_IN = 1'b1; MAG_IN = mag; SIGN_IN = sign;
    step(acc);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    VALID_IN = 1'b0;
    step(acc);
    check({tag, "_latency_valid"}, 32'(VALID_OUT), 32'd1);
    check({tag, "_value"}, 32'(VALUE_OUT), 32'(expv));
    check({tag, "_ovf"}, 32'(OVERFLOW), 32'(expo));
    CLEAR = clr;
    step(acc);
    CLEAR = 1'b0;
  endtask

  initial begin
    bit acc;
    int nxt;
    int mg;

    @(negedge CLK);
    RST = 1'b1;
    step(acc);
    step(acc);
    RST = 1'b0;
    #1;
    check("rst_valid_out", 32'(VALID_OUT), 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    check("rst_sticky", 32'(OVERFLOW_STICKY), 32'd0);
    check("rst_ready_out", 32'(READY_OUT), 32'd1);

    send_one("neg_2p5", 8'h14, 1'b1, 8'hEC, 1'b0, 1'b0);
    send_one("pos_2p5", 8'h14, 1'b0, 8'h14, 1'b0, 1'b0);
    send_one("neg_full", 8'h80, 1'b1, 8'h80, 1'b0, 1'b0);
    send_one("neg_zero", 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    send_one("pos_max", 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0);
    check("sticky_clean", 32'(OVERFLOW_STICKY), 32'd0);
`ifdef FIXED_POINT_SIGN_APPLY_SAT_EN
    send_one("pos_ovf", 8'h80, 1'b0, 8'h7F, 1'b1, 1'b0);
    check("sticky_set", 32'(OVERFLOW_STICKY), 32'd1);
    send_one("neg_ovf", 8'hC0, 1'b1, 8'h80, 1'b1, 1'b0);
`else
    send_one("pos_ovf", 8'h80, 1'b0, 8'h80, 1'b1, 1'b0);
    check("sticky_set", 32'(OVERFLOW_STICKY), 32'd1);
    send_one("neg_ovf", 8'hC0, 1'b1, 8'h40, 1'b1, 1'b0);
`endif

    // Streaming with a three-cycle downstream stall.
    nxt = 0;
    for (int cyc = 0; cyc < 40 && (nxt < 8 || q.size() > 0); cyc++) begin
      READY_IN = !(cyc >= 3 && cyc <= 5);
      VALID_IN = (nxt < 8);
      MAG_IN   = W'(nxt + 1);
      SIGN_IN  = 1'b0;
      if (cyc == 5) begin
        #1;
        check("stall_ready_low", 32'(READY_OUT), 32'd0);
        #0;
      end
      step(acc);
      if (acc) nxt++;
    end
    VALID_IN = 1'b0;
    READY_IN = 1'b1;
    check("stream_sent", 32'(nxt), 32'd8);
    check("stream_drained", 32'(q.size()), 32'd0);

    // Reset with two samples in flight.
    READY_IN = 1'b0;
    VALID_IN = 1'b1; MAG_IN = 8'h90; SIGN_IN = 1'b0;
    step(acc);
    VALID_IN = 1'b1; MAG_IN = 8'h05; SIGN_IN = 1'b1;
    step(acc);
    VALID_IN = 1'b0;
    check("inflight_two", 32'(q.size()), 32'd2);
    RST = 1'b1;
    step(acc);
    RST = 1'b0;
    #1;
    check("midrst_valid_out", 32'(VALID_OUT), 32'd0);
    check("midrst_sticky", 32'(OVERFLOW_STICKY), 32'd0);
    check("midrst_ready_out", 32'(READY_OUT), 32'd1);
    READY_IN = 1'b1;
    for (int i = 0; i < 4; i++) step(acc);

    // CLEAR coincident with an overflowing output transfer.
`ifdef FIXED_POINT_SIGN_APPLY_SAT_EN
    send_one("clr_ovf", 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
`else
    send_one("clr_ovf", 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1);
`endif
    check("clr_wins", 32'(OVERFLOW_STICKY), 32'd0);

    // Random traffic, boundary-biased magnitudes.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       mg = M + $urandom_range(0, 1) - $urandom_range(0, 1);
        1:       mg = $urandom_range(0, 1) * ((1 << W) - 1);
        default: mg = $urandom_range(0, (1 << W) - 1);
      endcase
      MAG_IN   = W'(mg);
      SIGN_IN  = 1'($urandom_range(0, 1));
      VALID_IN = ($urandom_range(0, 3) != 0);
      READY_IN = ($urandom_range(0, 9) < 7);
      CLEAR    = ($urandom_range(0, 19) == 0);
      step(acc);
    end
    VALID_IN = 1'b0;
    READY_IN = 1'b1;
    CLEAR    = 1'b0;
    for (int i = 0; i < 4; i++) step(acc);
    check("final_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fixed_point_sign_apply.md
Name: fixed_point_sign_apply

Overview:
Inverse of the fixed-point absolute-value block. It takes an unsigned magnitude plus a sign bit and returns the signed two's-complement fixed-point value. Typical use: after magnitude-domain processing (e.g. divide or sqrt on |x|), to restore the sign stripped upstream. It is a 2-stage pipeline with valid/ready backpressure, per-sample overflow and a sticky overflow flag.

Parameters:
- WIDTH, 8, data width in bits for the magnitude in and the value out.
- FRAC_BITS, 3, number of fractional bits. Carried for interface consistency; it does not change the arithmetic.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- MAG_IN  in  WIDTH  unsigned magnitude, range 0..2^WIDTH-1.
- SIGN_IN  in  1  1 = result is negative.
- VALID_IN  in  1  input sample valid.
- READY_OUT  out  1  block can accept an input this cycle.
- VALUE_OUT  out  WIDTH  signed result.
- VALID_OUT  out  1  output sample valid.
- READY_IN  in  1  downstream accepts VALUE_OUT this cycle.
- OVERFLOW  out  1  result not representable; qualified by VALID_OUT.
- OVERFLOW_STICKY  out  1  set by any transferred OVERFLOW; cleared by RST or CLEAR.
- CLEAR  in  1  synchronous clear of OVERFLOW_STICKY; wins over a same-cycle set.

Behaviour:
- Reset values: VALID_OUT=0, OVERFLOW=0, OVERFLOW_STICKY=0, both stage valids=0, READY_OUT=1 in the cycle after RST. VALUE_OUT after reset is don't-care.
- Handshake:
  - Input transfer: VALID_IN & READY_OUT.
  - Output transfer: VALID_OUT & READY_IN.
  - VALUE_OUT and OVERFLOW stay stable while VALID_OUT=1 and READY_IN=0.
- Stage advance: stage k advances when it is empty or stage k+1 advances. Stage 2 advances when empty or READY_IN=1.
- READY_OUT = !s1_valid | s2_advance. This is combinational from READY_IN, with no bubble.
- Latency: 2 cycles from input transfer to VALID_OUT. Throughput is 1 sample per cycle when READY_IN is held high. There is no skid buffer beyond the 2 stages, so at most 2 samples are in flight.
- Stage 1 registers MAG_IN, SIGN_IN and ~MAG_IN.
- Stage 2 computes the result with M = 2^(WIDTH-1):
  - SIGN=0, MAG <= M-1: VALUE = MAG, OVERFLOW=0.
  - SIGN=0, MAG >= M: OVERFLOW=1.
  - SIGN=1, MAG <= M: VALUE = ~MAG + 1 (mod 2^WIDTH), OVERFLOW=0. MAG=M gives the most negative code exactly.
  - SIGN=1, MAG > M: OVERFLOW=1.
  - SIGN=1, MAG=0: VALUE=0, no negative zero.
- The overflow value depends on FIXED_POINT_SIGN_APPLY_SAT_EN (see Optional Feature).
- RST mid-operation: both in-flight samples are dropped with no output, and OVERFLOW_STICKY clears.
- CLEAR and an overflowing transfer in the same cycle: OVERFLOW_STICKY=0.

Optional Feature:
FIXED_POINT_SIGN_APPLY_SAT_EN
- Defined: on overflow, VALUE_OUT saturates to 2^(WIDTH-1)-1 for SIGN=0 and to -2^(WIDTH-1) for SIGN=1.
- Undefined: VALUE_OUT is the wrapped, truncated low WIDTH bits of the arithmetic result.
- OVERFLOW and OVERFLOW_STICKY behave identically in both builds.

Decomposition:
- Shared package fixed_point_pkg:
  - function/constants for the most positive and most negative codes for a given WIDTH;
  - the overflow-select encoding, shared with the abs, add and saturate blocks.
- One natural sub-module: fixed_point_negate_stage. It is one registered two's-complement negation with valid/ready, instantiated as stage 2. The top holds stage 1, the sticky logic and the ready chain.

Test Plan (WIDTH=8, FRAC_BITS=3, READY_IN=1 unless stated):
- MAG=0x14 (2.5), SIGN=1 -> 2 cycles later VALUE_OUT=0xEC (-2.5), OVERFLOW=0. MAG=0x14, SIGN=0 -> 0x14.
- MAG=0x80, SIGN=1 -> 0x80, OVERFLOW=0. MAG=0x00, SIGN=1 -> 0x00, OVERFLOW=0.
- MAG=0x80, SIGN=0 -> OVERFLOW=1, STICKY=1:
  - with the macro, VALUE=0x7F;
  - without it, VALUE=0x80.
- MAG=0xC0, SIGN=1 -> OVERFLOW=1:
  - with the macro, VALUE=0x80;
  - without it, VALUE=0x40.
- Stream 0x01..0x08 SIGN=0 with READY_IN low for cycles 3-5:
  - READY_OUT drops once 2 samples are held;
  - VALUE_OUT is stable while stalled;
  - output sequence is 0x01..0x08 in order, none lost or duplicated.
- Assert RST with 2 samples in flight -> next cycle VALID_OUT=0, STICKY=0, READY_OUT=1. CLEAR coincident with an overflow transfer -> STICKY stays 0.
